hp_iir_iq_sched: RTL and testbench

//  Sequencer for the DC-blocking high-pass IIR at the decimated rate (~33.2 kHz at 136 MHz/4096).

---
 rtl/hp_iir_iq_sched.sv | 255 +++++++++++++++++++++++++
 tb/tb_hp_iir_iq_sched.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hp_iir_iq_sched.sv
// hp_iir_iq_sched: DC-blocking high-pass IIR sequencer for the I/Q pair.
// One external pipelined multiplier is time-shared between the two channels.
module hp_iir_iq_sched #(
    parameter int                 MULT_LAT     = 1,
    parameter logic signed [7:0]  COEF_DEFAULT = 8'sd60
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic signed [7:0]  i_in,
    input  logic signed [7:0]  q_in,
    input  logic               cfg_we,
    input  logic signed [7:0]  cfg_coef,
    input  logic               cfg_bypass,
    input  logic               clear_state,
    output logic signed [7:0]  mult_a,
    output logic signed [7:0]  mult_b,
    output logic               mult_ce,
    input  logic signed [15:0] mult_result,
    output logic signed [7:0]  i_out,
    output logic signed [7:0]  q_out,
    output logic               out_valid,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL_I,
        S_WAIT_I,
        S_CAP_I,
        S_MUL_Q,
        S_WAIT_Q,
        S_CAP_Q,
        S_DONE
    } state_t;

    localparam logic [1:0] WAIT_LOAD = 2'(MULT_LAT > 1 ? MULT_LAT - 2 : 0);

    state_t r_state;
    state_t w_next;

    logic [1:0]        r_wcnt;
    logic signed [7:0] r_xi, r_xq;
    logic signed [7:0] r_x1_i, r_x1_q;
    logic signed [7:0] r_y1_i, r_y1_q;
    logic signed [7:0] r_coef;
    logic              r_bypass;
    logic              r_pcfg;
    logic signed [7:0] r_pcoef;
    logic              r_pbyp;
    logic              r_pclr;
    logic signed [7:0] r_ma, r_mb;
    logic signed [7:0] r_res_i, r_res_q;
    logic signed [7:0] r_i_out, r_q_out;
    logic              r_out_valid;
    logic              r_overrun;

    logic              w_idle;
    logic              w_done;
    logic              w_mul;
    logic              w_wait;
    logic              w_cap_i;
    logic              w_cap_q;
    logic              w_cfg_now;
    logic              w_clr_now;
    logic signed [7:0] w_x;
    logic signed [7:0] w_x1;
    logic signed [11:0] w_p;
    logic signed [11:0] w_s;
    logic signed [7:0] w_y;
    logic signed [7:0] w_res;
    logic              w_unused;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (sample_valid) w_next = S_MUL_I;
            S_MUL_I:  w_next = (MULT_LAT > 1) ? S_WAIT_I : S_CAP_I;
            S_WAIT_I: if (r_wcnt == 2'd0) w_next = S_CAP_I;
            S_CAP_I:  w_next = S_MUL_Q;
            S_MUL_Q:  w_next = (MULT_LAT > 1) ? S_WAIT_Q : S_CAP_Q;
            S_WAIT_Q: if (r_wcnt == 2'd0) w_next = S_CAP_Q;
            S_CAP_Q:  w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Multiplier drive: operands held between issue cycles
    always_comb begin
        mult_ce = 1'b0;
        mult_a  = r_ma;
        mult_b  = r_mb;
        unique case (r_state)
            S_MUL_I: begin
                mult_ce = 1'b1;
                mult_a  = r_coef;
                mult_b  = r_y1_i;
            end
            S_MUL_Q: begin
                mult_ce = 1'b1;
                mult_a  = r_coef;
                mult_b  = r_y1_q;
            end
            default: ;
        endcase
    end

    assign w_idle  = (r_state == S_IDLE);
    assign w_done  = (r_state == S_DONE);
    assign w_mul   = (r_state == S_MUL_I) || (r_state == S_MUL_Q);
    assign w_wait  = (r_state == S_WAIT_I) || (r_state == S_WAIT_Q);
    assign w_cap_i = (r_state == S_CAP_I);
    assign w_cap_q = (r_state == S_CAP_Q);

    assign busy      = !w_idle;
    assign i_out     = r_i_out;
    assign q_out     = r_q_out;
    assign out_valid = r_out_valid;
    assign overrun   = r_overrun;

    // Writes made while busy wait for the DONE->IDLE edge
    assign w_cfg_now = (w_idle && cfg_we) || (w_done && (cfg_we || r_pcfg));
    assign w_clr_now = (w_idle || w_done) && (clear_state || r_pclr);

    assign w_x  = w_cap_q ? r_xq : r_xi;
    assign w_x1 = w_cap_q ? r_x1_q : r_x1_i;

    // Floor of product/64, sign-extended to the 12-bit sum width
    assign w_p      = {{2{mult_result[15]}}, mult_result[15:6]};
    assign w_unused = ^mult_result[5:0];

    assign w_s = 12'(w_x) - 12'(w_x1) + w_p;

    always_comb begin
        w_y = w_s[7:0];
        if (w_s > 12'sd127) begin
            w_y = 8'sd127;
        end else if (w_s < -12'sd128) begin
            w_y = -8'sd128;
        end
    end

    assign w_res = r_bypass ? w_x : w_y;

    // Sample latch, operand hold and wait counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xi   <= '0;
            r_xq   <= '0;
            r_ma   <= '0;
            r_mb   <= '0;
            r_wcnt <= '0;
        end else begin
            if (w_idle && sample_valid) begin
                r_xi <= i_in;
                r_xq <= q_in;
            end
            if (w_mul) begin
                r_ma   <= r_coef;
                r_mb   <= (r_state == S_MUL_I) ? r_y1_i : r_y1_q;
                r_wcnt <= WAIT_LOAD;
            end else if (w_wait) begin
                r_wcnt <= r_wcnt - 2'd1;
            end
        end
    end

    // Channel history and per-sequence results
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x1_i  <= '0;
            r_x1_q  <= '0;
            r_y1_i  <= '0;
            r_y1_q  <= '0;
            r_res_i <= '0;
            r_res_q <= '0;
        end else begin
            if (w_clr_now) begin
                r_x1_i <= '0;
                r_x1_q <= '0;
                r_y1_i <= '0;
                r_y1_q <= '0;
            end else if (w_cap_i) begin
                r_x1_i  <= w_x;
                r_y1_i  <= w_y;
                r_res_i <= w_res;
            end else if (w_cap_q) begin
                r_x1_q  <= w_x;
                r_y1_q  <= w_y;
                r_res_q <= w_res;
            end
        end
    end

    // Coefficient, bypass and deferred writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_coef   <= COEF_DEFAULT;
            r_bypass <= 1'b0;
            r_pcfg   <= 1'b0;
            r_pcoef  <= '0;
            r_pbyp   <= 1'b0;
            r_pclr   <= 1'b0;
        end else begin
            if (w_cfg_now) begin
                r_coef   <= cfg_we ? cfg_coef : r_pcoef;
                r_bypass <= cfg_we ? cfg_bypass : r_pbyp;
                r_pcfg   <= 1'b0;
            end else if (cfg_we) begin
                r_pcfg  <= 1'b1;
                r_pcoef <= cfg_coef;
                r_pbyp  <= cfg_bypass;
            end
            if (w_clr_now) begin
                r_pclr <= 1'b0;
            end else if (clear_state) begin
                r_pclr <= 1'b1;
            end
        end
    end

    // Output registers and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_i_out     <= '0;
            r_q_out     <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= w_done;
            if (w_done) begin
                r_i_out <= r_res_i;
                r_q_out <= r_res_q;
            end
            if (sample_valid && !w_idle) begin
                r_overrun <= 1'b1;
            end else if (cfg_we) begin
                r_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hp_iir_iq_sched.sv
// tb_hp_iir_iq_sched: runs MULT_LAT=1 and MULT_LAT=3 instances side by side
// on one stimulus stream against an arithmetic model of the filter.
module tb_hp_iir_iq_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              sample_valid;
    logic signed [7:0] i_in, q_in;
    logic              cfg_we;
    logic signed [7:0] cfg_coef;
    logic              cfg_bypass;
    logic              clear_state;

    logic signed [7:0]  ma_a, mb_a, io_a, qo_a;
    logic signed [7:0]  ma_b, mb_b, io_b, qo_b;
    logic               ce_a, ov_a, busy_a, orun_a;
    logic               ce_b, ov_b, busy_b, orun_b;
    logic signed [15:0] res_a, res_b, pb0, pb1;

    int checks = 0;
    int errors = 0;

    hp_iir_iq_sched #(.MULT_LAT(1), .COEF_DEFAULT(8'sd60)) u_a (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .i_in(i_in), .q_in(q_in), .cfg_we(cfg_we), .cfg_coef(cfg_coef),
        .cfg_bypass(cfg_bypass), .clear_state(clear_state),
        .mult_a(ma_a), .mult_b(mb_a), .mult_ce(ce_a), .mult_result(res_a),
        .i_out(io_a), .q_out(qo_a), .out_valid(ov_a), .busy(busy_a),
        .overrun(orun_a)
    );

    hp_iir_iq_sched #(.MULT_LAT(3), .COEF_DEFAULT(8'sd60)) u_b (
        .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
        .i_in(i_in), .q_in(q_in), .cfg_we(cfg_we), .cfg_coef(cfg_coef),
        .cfg_bypass(cfg_bypass), .clear_state(clear_state),
        .mult_a(ma_b), .mult_b(mb_b), .mult_ce(ce_b), .mult_result(res_b),
        .i_out(io_b), .q_out(qo_b), .out_valid(ov_b), .busy(busy_b),
        .overrun(orun_b)
    );

    // Multiplier models; junk is loaded on idle cycles to expose mistimed capture
    always_ff @(posedge clk) begin
        res_a <= ce_a ? ma_a * mb_a : 16'sh5a5a;
        pb0   <= ce_b ? ma_b * mb_b : 16'sh5a5a;
        pb1   <= pb0;
        res_b <= pb1;
    end

    int m_coef, m_byp, m_x1i, m_y1i, m_x1q, m_y1q, m_orun;
    logic signed [7:0] g_ia, g_qa;

    function automatic int floor_div64(input int v);
        if (v >= 0) return v / 64;
        return -((-v + 63) / 64);
    endfunction

    function automatic int sat8(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int iir(input int x, input int x1, input int y1, input int c);
        return sat8(x - x1 + floor_div64(c * y1));
    endfunction

    task automatic model_reset();
        m_coef = 60; m_byp = 0; m_orun = 0;
        m_x1i = 0; m_y1i = 0; m_x1q = 0; m_y1q = 0;
    endtask

    task automatic model_clear();
        m_x1i = 0; m_y1i = 0; m_x1q = 0; m_y1q = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        sample_valid = 0; cfg_we = 0; clear_state = 0;
        cfg_coef = 0; cfg_bypass = 0; i_in = 0; q_in = 0;
    endtask

    task automatic set_cfg(input int c, input int byp);
        cfg_we = 1; cfg_coef = 8'(c); cfg_bypass = byp[0];
        tick();
        cfg_we = 0;
        tick();
        m_coef = c; m_byp = byp; m_orun = 0;
    endtask

    // One sample through both instances; optional strobes at cycle T+k
    task automatic do_sample(input string tag, input int xi, input int xq,
                             input bit clr_with, input int cfg_k, input int cfg_c,
                             input int clr_k, input int sv_k);
        int ei, eq, yi, yq, ka, kb, na, nb;
        logic signed [7:0] cia, cqa, cib, cqb;
        cia = 'x; cqa = 'x; cib = 'x; cqb = 'x;
        if (clr_with) model_clear();
        yi = iir(xi, m_x1i, m_y1i, m_coef);
        yq = iir(xq, m_x1q, m_y1q, m_coef);
        ei = m_byp ? xi : yi;
        eq = m_byp ? xq : yq;
        m_x1i = xi; m_y1i = yi; m_x1q = xq; m_y1q = yq;

        i_in = 8'(xi); q_in = 8'(xq);
        sample_valid = 1; clear_state = clr_with;
        tick();
        ka = -1; kb = -1; na = 0; nb = 0;
        for (int k = 1; k <= 14; k++) begin
            sample_valid = (k == sv_k);
            i_in = 8'($urandom); q_in = 8'($urandom);
            cfg_we = (k == cfg_k);
            cfg_coef = 8'(cfg_c);
            cfg_bypass = m_byp[0];
            clear_state = (k == clr_k);
            if (ov_a) begin
                na++;
                if (ka < 0) begin ka = k; cia = io_a; cqa = qo_a; end
            end
            if (ov_b) begin
                nb++;
                if (kb < 0) begin kb = k; cib = io_b; cqb = qo_b; end
            end
            tick();
        end
        idle_inputs();

        if (cfg_k > 0) m_coef = cfg_c;
        if (sv_k > 0 && cfg_k > 0) m_orun = (sv_k >= cfg_k) ? 1 : 0;
        else if (sv_k > 0) m_orun = 1;
        else if (cfg_k > 0) m_orun = 0;
        if (clr_k > 0) model_clear();
        g_ia = cia; g_qa = cqa;

        checks++;
        if (ka != 6 || na != 1) begin
            errors++;
            $display("FAIL %s lat1_strobe: at T+%0d count %0d, want T+6 count 1", tag, ka, na);
        end
        checks++;
        if (kb != 10 || nb != 1) begin
            errors++;
            $display("FAIL %s lat3_strobe: at T+%0d count %0d, want T+10 count 1", tag, kb, nb);
        end
        checks++;
        if (cia !== 8'(ei) || cqa !== 8'(eq)) begin
            errors++;
            $display("FAIL %s lat1_iq: got %0d/%0d want %0d/%0d", tag, cia, cqa, ei, eq);
        end
        checks++;
        if (cib !== 8'(ei) || cqb !== 8'(eq)) begin
            errors++;
            $display("FAIL %s lat3_iq: got %0d/%0d want %0d/%0d", tag, cib, cqb, ei, eq);
        end
        checks++;
        if (io_a !== 8'(ei) || qo_b !== 8'(eq)) begin
            errors++;
            $display("FAIL %s hold: got %0d/%0d want %0d/%0d", tag, io_a, qo_b, ei, eq);
        end
        checks++;
        if (orun_a !== m_orun[0] || orun_b !== m_orun[0] || busy_a || busy_b) begin
            errors++;
            $display("FAIL %s overrun_busy: got %b%b busy %b%b want %0d",
                     tag, orun_a, orun_b, busy_a, busy_b, m_orun);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick(); tick();
        checks++;
        if ({io_a, qo_a, ov_a, busy_a, orun_a, ce_a, ma_a, mb_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got io %0d qo %0d ov %b busy %b orun %b ce %b a %0d b %0d, want all 0",
                     io_a, qo_a, ov_a, busy_a, orun_a, ce_a, ma_a, mb_a);
        end
        checks++;
        if ({io_b, qo_b, ov_b, busy_b, orun_b, ce_b, ma_b, mb_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got io %0d qo %0d ov %b busy %b orun %b ce %b a %0d b %0d, want all 0",
                     io_b, qo_b, ov_b, busy_b, orun_b, ce_b, ma_b, mb_b);
        end
        rst_n = 1;
        tick();
        model_reset();
    endtask

    task automatic test_step();
        int want [5] = '{64, 60, 56, 52, 48};
        test_reset();
        for (int n = 0; n < 4; n++) do_sample("step0", 0, $urandom_range(0, 40), 0, -1, 0, -1, -1);
        for (int n = 0; n < 5; n++) begin
            do_sample("step", 64, 0, 0, -1, 0, -1, -1);
            checks++;
            if (g_ia !== 8'(want[n])) begin
                errors++;
                $display("FAIL step_%0d: got %0d want %0d", n, g_ia, want[n]);
            end
        end
    endtask

    task automatic test_saturation();
        test_reset();
        do_sample("sat0", -128, 127, 0, -1, 0, -1, -1);
        do_sample("sat1", 127, -128, 0, -1, 0, -1, -1);
        checks++;
        if (g_ia !== 8'sd127 || g_qa !== -8'sd128) begin
            errors++;
            $display("FAIL saturation: got %0d/%0d want 127/-128", g_ia, g_qa);
        end
    endtask

    task automatic test_overrun();
        do_sample("ovr", 20, -20, 0, -1, 0, -1, 2);
        do_sample("done_drop", -7, 33, 0, -1, 0, -1, 5);
        set_cfg(m_coef, m_byp);
        checks++;
        if (orun_a !== 1'b0 || orun_b !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b/%b want 0/0", orun_a, orun_b);
        end
    endtask

    task automatic test_cfg_busy();
        do_sample("cfg_busy", 50, -50, 0, 2, 32, -1, -1);
        do_sample("cfg_next", 90, -90, 0, -1, 0, -1, -1);
        set_cfg(60, 0);
    endtask

    task automatic test_clear();
        do_sample("pre_clr", 100, -100, 0, -1, 0, -1, -1);
        do_sample("clr_with", 30, 40, 1, -1, 0, -1, -1);
        do_sample("clr_busy", 77, -77, 0, -1, 0, 3, -1);
        do_sample("post_clr", 10, 10, 0, -1, 0, -1, -1);
    endtask

    task automatic test_bypass();
        set_cfg(60, 1);
        do_sample("byp_on", -90, 111, 0, -1, 0, -1, -1);
        set_cfg(60, 0);
        do_sample("byp_off", 5, -5, 0, -1, 0, -1, -1);
    endtask

    task automatic test_reset_mid();
        int na, nb;
        do_sample("pre_rst", 120, -120, 0, -1, 0, -1, -1);
        i_in = 8'sd99; q_in = -8'sd99; sample_valid = 1;
        tick();
        sample_valid = 0;
        tick(); tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        na = 0; nb = 0;
        for (int k = 0; k < 12; k++) begin
            if (ov_a) na++;
            if (ov_b) nb++;
            tick();
        end
        model_reset();
        checks++;
        if (na != 0 || nb != 0 || io_a !== 0 || qo_b !== 0 || busy_b) begin
            errors++;
            $display("FAIL reset_mid: strobes %0d/%0d io %0d qo %0d busy %b, want none and 0",
                     na, nb, io_a, qo_b, busy_b);
        end
        do_sample("post_rst", 64, -64, 0, -1, 0, -1, -1);
    endtask

    task automatic test_random();
        logic signed [7:0] t1, t2;
        int r;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                t1 = 8'($urandom);
                set_cfg(t1, $urandom_range(0, 3) == 0 ? 1 : 0);
            end
            t1 = 8'($urandom);
            t2 = 8'($urandom);
            do_sample("rand", t1, t2, r == 1, -1, 0, -1, -1);
        end
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        model_reset();
        test_reset();
        test_step();
        test_saturation();
        test_overrun();
        test_cfg_busy();
        test_clear();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
